// File: rtl/call_stack_pkg.sv
// Shared types and defaults for the call/return address stack.
// Build option: CALL_STACK_WRAP_EN makes a push while full overwrite the oldest entry.
package call_stack_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    NOP,
    PUSH,
    POP,
    REPLACE
  } stack_op_e;

  function automatic stack_op_e decode_op(
    input logic push,
    input logic pop
  );
    stack_op_e op;
    case ({push, pop})
      2'b10:   op = PUSH;
      2'b01:   op = POP;
      2'b11:   op = REPLACE;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/call_ret_stack_if.sv
// Control-side bundle of the call/return stack.
// master = control unit / PC select, slave = the stack.
interface call_ret_stack_if #(
  parameter int ADDR_W = 19,
  parameter int CNT_W  = 5
);

  logic              en_stack;
  logic              call_en;
  logic              ret_en;
  logic [ADDR_W-1:0] push_addr;
  logic              err_clr;
  logic [ADDR_W-1:0] ret_addr;
  logic              ret_valid;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output en_stack, call_en, ret_en, push_addr, err_clr,
    input  ret_addr, ret_valid, full, empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  en_stack, call_en, ret_en, push_addr, err_clr,
    output ret_addr, ret_valid, full, empty, count,
    output overflow, underflow
  );

endinterface

// File: rtl/call_ret_stack_ptr.sv
// Stack pointer and occupancy counter with full/empty decode.
// hold_cnt lets sp advance while count stays put (circular overwrite).
module stack_ptr_ctr #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int SP_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             hold_cnt,
  output logic [SP_W-1:0]  sp,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp    <= '0;
      count <= '0;
    end else if (up && !down) begin
      sp <= sp + 1'b1;
      if (!hold_cnt)
        count <= count + 1'b1;
    end else if (down && !up) begin
      sp    <= sp - 1'b1;
      count <= count - 1'b1;
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/call_ret_stack.sv
// Hardware return-address stack: storage, read mux and sticky error flags.
// Build option: CALL_STACK_WRAP_EN selects circular overwrite on push while full.
module call_ret_stack
  import call_stack_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  call_ret_stack_if.slave bus
);

  localparam int SP_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];

  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  top;
  logic [SP_W-1:0]  waddr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             we;
  logic             up;
  logic             down;
  logic             hold_cnt;
  logic             ovf_set;
  logic             udf_set;
  logic             overflow;
  logic             underflow;
  stack_op_e        op;

  assign push = bus.en_stack & bus.call_en;
  assign pop  = bus.en_stack & bus.ret_en;
  assign op   = decode_op(push, pop);
  assign top  = sp - 1'b1;

  always_comb begin
    we       = 1'b0;
    waddr    = sp;
    up       = 1'b0;
    down     = 1'b0;
    hold_cnt = 1'b0;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    unique case (op)
      PUSH: begin
        if (!full) begin
          we = 1'b1;
          up = 1'b1;
        end else begin
          ovf_set = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          we       = 1'b1;
          up       = 1'b1;
          hold_cnt = 1'b1;
`endif
        end
      end
      POP: begin
        if (!empty)
          down = 1'b1;
        else
          udf_set = 1'b1;
      end
      REPLACE: begin
        we = 1'b1;
        if (empty) begin
          up      = 1'b1;
          udf_set = 1'b1;
        end else begin
          waddr = top;
        end
      end
      default: ;
    endcase
  end

  stack_ptr_ctr #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .SP_W  (SP_W)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .up       (up),
    .down     (down),
    .hold_cnt (hold_cnt),
    .sp       (sp),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= bus.push_addr;
  end

  // a new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~bus.err_clr);
      underflow <= udf_set | (underflow & ~bus.err_clr);
    end
  end

  assign bus.ret_addr  = empty ? '0 : mem[top];
  assign bus.ret_valid = ~empty;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

endmodule

// File: tb/tb_call_ret_stack.sv
// Directed scoreboard bench for call_ret_stack with DEPTH=4.
// Expected values depend on CALL_STACK_WRAP_EN for the overflow case.
module tb_call_ret_stack;

  localparam int ADDR_W = 19;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  localparam int S_RET = 0;
  localparam int S_VAL = 1;
  localparam int S_CNT = 2;
  localparam int S_EMP = 3;
  localparam int S_FUL = 4;
  localparam int S_OVF = 5;
  localparam int S_UDF = 6;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] v;
  } exp_t;

  logic clk;
  logic rst;

  call_ret_stack_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  call_ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.sel = 4'(sel);
    e.v   = v;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic step(
    input logic              en,
    input logic              call,
    input logic              ret,
    input logic [ADDR_W-1:0] addr,
    input logic              clr
  );
    @(posedge clk);
    #1;
    bus.en_stack  = en;
    bus.call_en   = call;
    bus.ret_en    = ret;
    bus.push_addr = addr;
    bus.err_clr   = clr;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a);
    step(1'b1, 1'b1, 1'b0, a, 1'b0);
  endtask

  task automatic pop();
    step(1'b1, 1'b0, 1'b1, '0, 1'b0);
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic expect_reset_vals(input string tag);
    expect_v({tag, "_cnt"}, S_CNT, 0);
    expect_v({tag, "_empty"}, S_EMP, 1);
    expect_v({tag, "_full"}, S_FUL, 0);
    expect_v({tag, "_valid"}, S_VAL, 0);
    expect_v({tag, "_ret"}, S_RET, 0);
    expect_v({tag, "_ovf"}, S_OVF, 0);
    expect_v({tag, "_udf"}, S_UDF, 0);
  endtask

  // monitor: compares every queued expectation at the falling edge
  always @(negedge clk) begin
    exp_t        e;
    string       n;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (int'(e.sel))
        S_RET:   act = 32'(bus.ret_addr);
        S_VAL:   act = 32'(bus.ret_valid);
        S_CNT:   act = 32'(bus.count);
        S_EMP:   act = 32'(bus.empty);
        S_FUL:   act = 32'(bus.full);
        S_OVF:   act = 32'(bus.overflow);
        default: act = 32'(bus.underflow);
      endcase
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", n, act, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b0;
    bus.en_stack  = 1'b0;
    bus.call_en   = 1'b0;
    bus.ret_en    = 1'b0;
    bus.push_addr = '0;
    bus.err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    nop();
    expect_reset_vals("reset");

    // pop on empty
    pop();
    expect_v("udf_pop_ret", S_RET, 0);
    expect_v("udf_pop_valid", S_VAL, 0);
    nop();
    expect_v("udf_flag", S_UDF, 1);
    expect_v("udf_cnt", S_CNT, 0);
    expect_v("udf_empty", S_EMP, 1);

    // LIFO order
    push(19'h00010);
    push(19'h00020);
    push(19'h00030);
    pop();
    expect_v("lifo_pop1", S_RET, 32'h30);
    expect_v("lifo_cnt3", S_CNT, 3);
    pop();
    expect_v("lifo_pop2", S_RET, 32'h20);
    pop();
    expect_v("lifo_pop3", S_RET, 32'h10);
    expect_v("lifo_cnt1", S_CNT, 1);
    nop();
    expect_v("lifo_empty", S_EMP, 1);
    expect_v("lifo_cnt0", S_CNT, 0);
    expect_v("lifo_stale_ret", S_RET, 0);
    expect_v("lifo_valid", S_VAL, 0);

    // tail-call replace
    push(19'h00011);
    step(1'b1, 1'b1, 1'b1, 19'h7FFFF, 1'b0);
    expect_v("repl_old_top", S_RET, 32'h11);
    expect_v("repl_cnt_in", S_CNT, 1);
    nop();
    expect_v("repl_new_top", S_RET, 32'h7FFFF);
    expect_v("repl_cnt", S_CNT, 1);
    pop();
    expect_v("repl_pop", S_RET, 32'h7FFFF);

    // clear errors
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    expect_v("clr_udf_before", S_UDF, 1);
    nop();
    expect_v("clr_udf_after", S_UDF, 0);
    expect_v("clr_empty", S_EMP, 1);

    // overflow
    push(19'h1);
    push(19'h2);
    push(19'h3);
    push(19'h4);
    push(19'h5);
    expect_v("ovf_full", S_FUL, 1);
    expect_v("ovf_cnt_in", S_CNT, 4);
    expect_v("ovf_flag_in", S_OVF, 0);
    nop();
    expect_v("ovf_cnt", S_CNT, 4);
    expect_v("ovf_flag", S_OVF, 1);
`ifdef CALL_STACK_WRAP_EN
    expect_v("ovf_top", S_RET, 32'h5);
    pop();
    expect_v("ovf_pop1", S_RET, 32'h5);
    pop();
    expect_v("ovf_pop2", S_RET, 32'h4);
    pop();
    expect_v("ovf_pop3", S_RET, 32'h3);
    pop();
    expect_v("ovf_pop4", S_RET, 32'h2);
`else
    expect_v("ovf_top", S_RET, 32'h4);
    pop();
    expect_v("ovf_pop1", S_RET, 32'h4);
    pop();
    expect_v("ovf_pop2", S_RET, 32'h3);
    pop();
    expect_v("ovf_pop3", S_RET, 32'h2);
    pop();
    expect_v("ovf_pop4", S_RET, 32'h1);
`endif
    nop();
    expect_v("ovf_drain_empty", S_EMP, 1);

    // disabled stack ignores call
    step(1'b0, 1'b1, 1'b0, 19'h55, 1'b0);
    nop();
    expect_v("dis_cnt", S_CNT, 0);
    expect_v("dis_empty", S_EMP, 1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    expect_v("clr_ovf_before", S_OVF, 1);
    nop();
    expect_v("clr_ovf_after", S_OVF, 0);
    expect_v("clr_udf_after2", S_UDF, 0);

    // error set wins over clear
    step(1'b1, 1'b0, 1'b1, '0, 1'b1);
    nop();
    expect_v("setwins_udf", S_UDF, 1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // replace on empty acts as push plus underflow
    step(1'b1, 1'b1, 1'b1, 19'h00ABC, 1'b0);
    nop();
    expect_v("repl_empty_top", S_RET, 32'hABC);
    expect_v("repl_empty_cnt", S_CNT, 1);
    expect_v("repl_empty_udf", S_UDF, 1);

    // async reset mid-burst
    push(19'h00A);
    push(19'h00B);
    nop();
    expect_v("burst_cnt", S_CNT, 3);
    @(posedge clk);
    #2;
    rst = 1'b0;
    expect_reset_vals("async");
    @(negedge clk);
    rst = 1'b1;
    push(19'h00077);
    nop();
    expect_v("post_rst_top", S_RET, 32'h77);
    expect_v("post_rst_cnt", S_CNT, 1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/call_ret_stack.md
# call_ret_stack

Hardware return-address stack for the 19-bit processor. It consumes the `call_en`, `ret_en` and `en_stack` strobes produced by the control unit. On a call it pushes the return address; on a return it supplies the popped target to the PC-select logic in the same cycle. It sits beside the PC register in the fetch/execute path and owns all call-depth bookkeeping, including overflow and underflow error reporting.

## Interface
Parameters:
- `ADDR_W`, default 19: return-address width in bits, equal to the PC width.
- `DEPTH`, default 16: number of stack entries; must be a power of 2 and at least 2.
- `CNT_W`, default $clog2(DEPTH)+1: width of the occupancy count.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `en_stack`  in  1: stack enable from the control unit; `call_en` and `ret_en` are ignored while it is low.
- `call_en`  in  1: push request.
- `ret_en`  in  1: pop request.
- `push_addr`  in  ADDR_W: return address to push, PC+1 from the datapath.
- `err_clr`  in  1: synchronous clear of the sticky error flags.
- `ret_addr`  out  ADDR_W: current top of stack, combinational from stored state.
- `ret_valid`  out  1: high when `ret_addr` is meaningful, i.e. `count != 0`.
- `full`  out  1: `count == DEPTH`.
- `empty`  out  1: `count == 0`.
- `count`  out  CNT_W: current number of occupied entries.
- `overflow`  out  1: sticky; set when a push was lost.
- `underflow`  out  1: sticky; set by a pop on an empty stack.

## Operation
- Storage is an array `mem[DEPTH]` addressed by a write pointer `sp` (log2 DEPTH bits, wraps modulo DEPTH).
- Top of stack is `mem[sp-1]`.
- Effective requests: `push = en_stack & call_en` and `pop = en_stack & ret_en`.
- Push only: `mem[sp] <= push_addr`, `sp <= sp+1`, `count <= count+1`.
- Pop only with `count > 0`: `sp <= sp-1`, `count <= count-1`. The popped value is the `ret_addr` visible during that same cycle.
- Pop only with `count == 0`: no state change except `underflow <= 1`. `ret_addr` reads 0 and `ret_valid` is 0.
- Push and pop in the same cycle (tail call): the top entry is replaced, `mem[sp-1] <= push_addr`. `sp` and `count` are unchanged. `ret_addr` shows the old top during that cycle.
- Push and pop in the same cycle with an empty stack: behaves as a push, and `underflow <= 1`.
- Push while full: see Configuration.
- `err_clr` clears `overflow` and `underflow`. If `err_clr` coincides with a new error event, the set wins.
- When `count == 0`, `ret_addr` is forced to 0 and never exposes stale contents.

## Timing
- Reset values:
  - `sp` = 0 and `count` = 0
  - `empty` = 1, `full` = 0, `ret_valid` = 0
  - `ret_addr` = 0
  - `overflow` = 0, `underflow` = 0
  - `mem` contents are not reset.
- Read latency is 0 cycles: `ret_addr` reflects the registered state, so a return uses it in its own cycle.
- Push-to-visible latency is 1 cycle: a pushed value appears on `ret_addr` after the next rising edge.
- `full`, `empty`, `count` and `ret_valid` are decoded from registered `count`. They update one edge after the request.
- Reset asserted mid-sequence clears the pointer and count immediately and asynchronously. Release is synchronous to `clk`.

## Configuration
- Macro: `CALL_STACK_WRAP_EN`.
- When the macro is defined, a push while full is circular. It writes `mem[sp]`, overwriting the oldest entry, then `sp <= sp+1`. `count` stays at DEPTH and `overflow <= 1`.
- When the macro is undefined, a push while full is dropped. `sp`, `count` and `mem` are unchanged and `overflow <= 1`.
- Push and pop in the same cycle while full is a replace in both builds, with no overflow.

## Structure
- Shared package `call_stack_pkg` holds:
  - the default `ADDR_W` and `DEPTH` localparams
  - a `stack_op_e` enum with values `NOP`, `PUSH`, `POP` and `REPLACE`, decoded from push/pop.
- One sub-module, `stack_ptr_ctr`, holds the `sp` and `count` registers. It has up/down/hold inputs and produces the `full` and `empty` decode.
- The top level contains the storage array, the read mux and the error flags.

## Test plan
- Reset with `DEPTH`=4, then pop: `underflow`=1, `ret_addr`=0, `count`=0, `empty`=1.
- Push 0x00010, 0x00020, 0x00030, then pop three times: `ret_addr` reads 0x00030, 0x00020, 0x00010 in the pop cycles, and `empty`=1 afterwards.
- Push 0x00011, then push and pop together with `push_addr`=0x7FFFF: `count` stays 1, and the next cycle `ret_addr`=0x7FFFF.
- Fill 4 entries (0x1 to 0x4), then push 0x5:
  - without the macro: `count`=4, top remains 0x4, `overflow`=1
  - with the macro: top is 0x5 and the fourth pop yields 0x2.
- `call_en`=1 with `en_stack`=0: no change to `count`. Then assert `err_clr`: both flags read 0 the next cycle.
- Assert `rst` low mid-burst with `count`=3: outputs return to reset values without waiting for a clock edge.
